// File: rtl/lc_cfg_pkg.sv
// lc_cfg_pkg: shared constants, state type and CRC helper for the cbit loader
package lc_cfg_pkg;
  localparam int CBIT_W = 21;
  localparam int C_ON_BIT = 20;
  localparam int SEQ_MODE_LSB = 16;
  localparam int LUT_INIT_LSB = 0;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/lc_cbit_serializer.sv
// lc_cbit_serializer: holding + shift register emitting one word MSB-first on divided strobes
import lc_cfg_pkg::*;
module lc_cbit_serializer #(
  parameter int CBIT_W = 21,
  parameter int SHIFT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [CBIT_W-1:0] data,
  output logic              empty,
  output logic              strobe,
  output logic              sdata,
  output logic              bit_done
);
  localparam int DW = SHIFT_DIV > 1 ? $clog2(SHIFT_DIV) : 1;
  localparam int BW = $clog2(CBIT_W);
  logic [CBIT_W-1:0] hold, sreg;
  logic hold_v, act, free;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  assign strobe = act && div_cnt == '0;
  assign bit_done = strobe && bit_cnt == BW'(CBIT_W - 1);
  assign free = !act || bit_done;
  assign empty = !hold_v;
  assign sdata = sreg[CBIT_W-1];
  // Reload from the holding register (or straight from input) as the previous word finishes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      sreg <= '0;
      hold_v <= 1'b0;
      act <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (clr) begin
      hold_v <= 1'b0;
      act <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (free) begin
      act <= hold_v || load;
      sreg <= hold_v ? hold : data;
      bit_cnt <= '0;
      div_cnt <= '0;
      hold_v <= hold_v && load;
      if (hold_v && load) hold <= data;
    end else begin
      if (strobe) sreg <= {sreg[CBIT_W-2:0], 1'b0};
      if (strobe) bit_cnt <= bit_cnt + 1'b1;
      div_cnt <= div_cnt == DW'(SHIFT_DIV - 1) ? '0 : div_cnt + 1'b1;
      if (load) hold <= data;
      if (load) hold_v <= 1'b1;
    end
endmodule

// File: rtl/lc_cbit_loader.sv
// lc_cbit_loader: frames cbit words into the LogicCell2 shift chain; CRC under LC_CBIT_LOADER_CRC_EN
import lc_cfg_pkg::*;
module lc_cbit_loader #(
  parameter int NUM_CELLS = 8,
  parameter int CBIT_W = 21,
  parameter int SHIFT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CBIT_W-1:0] s_data,
  input  logic              s_last,
  input  logic              abort,
  output logic              cfg_shift,
  output logic              cfg_sdata,
  output logic              cfg_latch,
  output logic              busy,
  output logic              done,
  output logic              err_frame,
  output logic [15:0]       crc
);
  localparam int WW = $clog2(NUM_CELLS + 1);
  state_t state, state_nx;
  logic [WW-1:0] word_cnt;
  logic complete, empty, strobe, sdata, bit_done, abort_act, acc, last_idx, bad, clr;
  assign s_ready = empty && !complete && (state == IDLE || state == SHIFT);
  assign abort_act = abort && state != IDLE;
  assign acc = s_valid && s_ready && !abort_act;
  assign last_idx = word_cnt == WW'(NUM_CELLS - 1);
  assign bad = acc && (s_last != last_idx);
  assign clr = abort_act || bad;
  assign cfg_shift = strobe;
  assign cfg_sdata = strobe && sdata;
  assign cfg_latch = state == LATCH;
  assign done = state == DONE;
  assign busy = state != IDLE;
  lc_cbit_serializer #(.CBIT_W(CBIT_W), .SHIFT_DIV(SHIFT_DIV)) u_ser (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(acc), .data(s_data),
    .empty(empty), .strobe(strobe), .sdata(sdata), .bit_done(bit_done)
  );
  // Frame sequencing: latch only once the final word's last bit has left the serializer
  always_comb
    state_nx = clr ? IDLE :
               state == IDLE ? (acc ? SHIFT : IDLE) :
               state == SHIFT ? (bit_done && complete && empty ? LATCH : SHIFT) :
               state == LATCH ? DONE : IDLE;
  // State, word count and sticky frame error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      word_cnt <= '0;
      complete <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr || state == DONE) word_cnt <= '0;
      else if (acc) word_cnt <= word_cnt + 1'b1;
      if (clr || state == DONE) complete <= 1'b0;
      else if (acc) complete <= s_last;
      if (bad) err_frame <= 1'b1;
      else if (acc && state == IDLE) err_frame <= 1'b0;
    end
`ifdef LC_CBIT_LOADER_CRC_EN
  logic [15:0] crc_q;
  logic fresh;
  assign crc = crc_q;
  // CRC over the serial stream, restarted from CRC_INIT on each frame's first strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      crc_q <= '0;
      fresh <= 1'b0;
    end else if (clr) begin
      crc_q <= '0;
      fresh <= 1'b0;
    end else begin
      if (acc && state == IDLE) fresh <= 1'b1;
      else if (strobe) fresh <= 1'b0;
      if (strobe) crc_q <= crc_step(fresh ? CRC_INIT : crc_q, sdata);
    end
`else
  assign crc = 16'h0000;
`endif
endmodule

// File: tb/tb_lc_cbit_loader.sv
// tb_lc_cbit_loader: directed checks of framing, pacing, errors, abort, reset and CRC
module tb_lc_cbit_loader;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_valid = 0, a_last = 0, a_abort = 0;
  logic [20:0] a_data = '0;
  logic a_ready, a_shift, a_sdata, a_latch, a_busy, a_done, a_err;
  logic [15:0] a_crc;
  logic b_valid = 0, b_last = 0, b_abort = 0;
  logic [20:0] b_data = '0;
  logic b_ready, b_shift, b_sdata, b_latch, b_busy, b_done, b_err;
  logic [15:0] b_crc;
  int n = 0, bad = 0;
`ifdef LC_CBIT_LOADER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  lc_cbit_loader #(.NUM_CELLS(2), .CBIT_W(21), .SHIFT_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .s_last(a_last), .abort(a_abort), .cfg_shift(a_shift), .cfg_sdata(a_sdata),
    .cfg_latch(a_latch), .busy(a_busy), .done(a_done), .err_frame(a_err), .crc(a_crc)
  );
  lc_cbit_loader #(.NUM_CELLS(1), .CBIT_W(21), .SHIFT_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_last(b_last), .abort(b_abort), .cfg_shift(b_shift), .cfg_sdata(b_sdata),
    .cfg_latch(b_latch), .busy(b_busy), .done(b_done), .err_frame(b_err), .crc(b_crc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] crc_model(input logic [63:0] bits, input int nb);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = nb - 1; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
  task automatic drain_a(output int ns, output int nl, output int nd);
    ns = 0; nl = 0; nd = 0;
    for (int i = 0; i < 80; i++) begin
      ns += int'(a_shift); nl += int'(a_latch); nd += int'(a_done);
      tick;
    end
  endtask
  task automatic good_frame_a(input string tag);
    int ns, nl, nd;
    a_valid = 1; a_data = 21'h000001; a_last = 0;
    tick;
    chk({tag, "_err_clr"}, a_err, 0);
    chk({tag, "_first_strobe"}, a_shift, 1);
    a_data = 21'h100000; a_last = 1;
    tick;
    a_valid = 0; a_last = 0;
    drain_a(ns, nl, nd);
    chk({tag, "_strobes"}, ns, 41);
    chk({tag, "_latch"}, nl, 1);
    chk({tag, "_done"}, nd, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [41:0] exp42;
    int ns, nl, nd, got;
    tick; tick;
    chk("rst_ready", a_ready, 1);
    chk("rst_shift", a_shift, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_latch", a_latch, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_crc", a_crc, 0);
    rst_n = 1;
    tick;
    // two-word frame, back-to-back
    exp42 = {21'h1A5A5A, 21'h0F0F0F};
    a_valid = 1; a_data = 21'h1A5A5A; a_last = 0;
    tick;
    chk("t1_busy", a_busy, 1);
    a_data = 21'h0F0F0F; a_last = 1;
    for (int i = 0; i < 42; i++) begin
      chk("t1_shift", a_shift, 1);
      chk("t1_sdata", a_sdata, exp42[41-i]);
      tick;
      if (i == 0) begin a_valid = 0; a_last = 0; end
    end
    chk("t1_latch", a_latch, 1);
    chk("t1_noshift", a_shift, 0);
    chk("t1_nodone", a_done, 0);
    tick;
    chk("t1_done", a_done, 1);
    chk("t1_busy_done", a_busy, 1);
    chk("t1_crc", a_crc, CRC_ON ? 32'(crc_model(64'(exp42), 42)) : 32'h0);
    tick;
    chk("t1_idle_busy", a_busy, 0);
    chk("t1_idle_done", a_done, 0);
    chk("t1_idle_ready", a_ready, 1);
    // single-cell frame, strobes every third cycle
    b_valid = 1; b_data = 21'h100000; b_last = 1;
    tick;
    b_valid = 0; b_last = 0;
    for (int c = 0; c < 61; c++) begin
      chk("t2_shift", b_shift, 32'(c % 3 == 0));
      chk("t2_sdata", b_sdata, 32'(c == 0));
      tick;
    end
    chk("t2_latch", b_latch, 1);
    tick;
    chk("t2_done", b_done, 1);
    tick;
    chk("t2_idle", b_busy, 0);
    // s_last on first word
    a_valid = 1; a_data = 21'h1FFFFF; a_last = 1;
    tick;
    a_valid = 0; a_last = 0;
    chk("t3_err", a_err, 1);
    chk("t3_busy", a_busy, 0);
    chk("t3_ready", a_ready, 1);
    tick;
    chk("t3_noshift", a_shift, 0);
    good_frame_a("t3");
    // missing s_last on final word
    a_valid = 1; a_data = 21'h0AAAAA; a_last = 0;
    tick; tick;
    a_valid = 0;
    chk("t3b_err", a_err, 1);
    chk("t3b_busy", a_busy, 0);
    drain_a(ns, nl, nd);
    chk("t3b_strobes", ns, 0);
    chk("t3b_latch", nl, 0);
    // abort after ten strobes
    a_valid = 1; a_data = 21'h1A5A5A; a_last = 0;
    tick;
    chk("t4_err_clr", a_err, 0);
    a_data = 21'h0F0F0F; a_last = 1;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (i == 0) begin a_valid = 0; a_last = 0; end
    end
    chk("t4_strobe10", a_shift, 1);
    a_abort = 1;
    tick;
    a_abort = 0;
    chk("t4_busy", a_busy, 0);
    chk("t4_shift", a_shift, 0);
    chk("t4_ready", a_ready, 1);
    chk("t4_err", a_err, 0);
    drain_a(ns, nl, nd);
    chk("t4_strobes", ns, 0);
    chk("t4_latch", nl, 0);
    chk("t4_done", nd, 0);
    // asynchronous reset mid-shift
    a_valid = 1; a_data = 21'h1A5A5A; a_last = 0;
    tick;
    a_data = 21'h0F0F0F; a_last = 1;
    tick;
    a_valid = 0; a_last = 0;
    tick; tick;
    chk("t5_pre_shift", a_shift, 1);
    #3 rst_n = 0;
    #1;
    chk("t5_shift", a_shift, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_ready", a_ready, 1);
    chk("t5_latch", a_latch, 0);
    chk("t5_done", a_done, 0);
    chk("t5_crc", a_crc, 0);
    #2 rst_n = 1;
    tick;
    good_frame_a("t5");
    // CRC over 21 zero bits
    b_valid = 1; b_data = 21'h000000; b_last = 1;
    tick;
    b_valid = 0; b_last = 0;
    got = 0;
    for (int i = 0; i < 80 && got == 0; i++) begin
      if (b_done) begin
        got = 1;
        chk("t6_crc", b_crc, CRC_ON ? 32'(crc_model(64'h0, 21)) : 32'h0);
      end else tick;
    end
    chk("t6_done_seen", got, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
